// File: rtl/uart_cmd_pkg.sv
// Shared constants, state types and the ASCII hex decoder for the UART register-command receiver.
// UART_RX_PARITY_EN adds the PARITY state to the PHY state type.
package uart_cmd_pkg;

  localparam logic [7:0] CH_R    = 8'h72;
  localparam logic [7:0] CH_EQ   = 8'h3D;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_7    = 8'h37;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_A_LO = 8'h61;
  localparam logic [7:0] CH_F_LO = 8'h66;
  localparam logic [7:0] CH_A_UP = 8'h41;
  localparam logic [7:0] CH_F_UP = 8'h46;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} phy_state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} phy_state_t;
`endif

  typedef enum logic [2:0] {P_R, P_IDX, P_EQ, P_HEX, P_EOL, P_SYNC} parse_state_t;

  // Returns {valid, nibble}; valid is 0 for anything outside 0-9, a-f, A-F.
  function automatic logic [4:0] hex2nib(input logic [7:0] c);
    logic [7:0] t;
    t = 8'd0;
    if (c >= CH_0 && c <= CH_9) begin
      t = c - CH_0;
      return {1'b1, t[3:0]};
    end
    if (c >= CH_A_LO && c <= CH_F_LO) begin
      t = c - CH_A_LO + 8'd10;
      return {1'b1, t[3:0]};
    end
    if (c >= CH_A_UP && c <= CH_F_UP) begin
      t = c - CH_A_UP + 8'd10;
      return {1'b1, t[3:0]};
    end
    return 5'd0;
  endfunction

endpackage

// File: rtl/uart_rx_phy.sv
// 8N1 receiver: 2-flop synchronizer, half-bit start validation, mid-bit sampling, stop check.
// With UART_RX_PARITY_EN defined the frame is 8E1 and a parity mismatch is reported as frame_err.
module uart_rx_phy
  import uart_cmd_pkg::*;
#(
  parameter int DIV = 234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2);
  // Terminal count is 0, so loading DIV-1 spaces samples exactly DIV clocks apart.
  localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);

  phy_state_t    state, state_nxt;
  logic [1:0]    sync_q;
  logic          rx_s;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic          brk, brk_nxt;
  logic [7:0]    rx_byte_nxt;
  logic          rx_valid_nxt, frame_err_nxt;
  logic          tick;
  logic          par_bad;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_nxt;
`endif

  assign rx_s = sync_q[1];
  assign tick = (cnt == '0);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = tick ? cnt : cnt - 1'b1;
    shreg_nxt     = shreg;
    bit_idx_nxt   = bit_idx;
    brk_nxt       = brk;
    rx_byte_nxt   = rx_byte;
    rx_valid_nxt  = 1'b0;
    frame_err_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nxt   = par_bad;
`endif
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          cnt_nxt   = HALF_LOAD;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (rx_s) begin
            state_nxt = S_IDLE;
          end else begin
            cnt_nxt     = FULL_LOAD;
            bit_idx_nxt = 3'd0;
            state_nxt   = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shreg_nxt   = {rx_s, shreg[7:1]};
          cnt_nxt     = FULL_LOAD;
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          par_bad_nxt = rx_s ^ (^shreg);
          cnt_nxt     = FULL_LOAD;
          state_nxt   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (brk) begin
          // Line held low past a bad stop bit: wait for it to release before hunting again.
          if (rx_s) begin
            brk_nxt   = 1'b0;
            state_nxt = S_IDLE;
          end
        end else if (tick) begin
          if (rx_s && !par_bad) begin
            rx_byte_nxt  = shreg;
            rx_valid_nxt = 1'b1;
            state_nxt    = S_IDLE;
          end else begin
            frame_err_nxt = 1'b1;
            if (rx_s) state_nxt = S_IDLE;
            else      brk_nxt   = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifndef UART_RX_PARITY_EN
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sync_q    <= 2'b11;
      cnt       <= '0;
      shreg     <= '0;
      bit_idx   <= '0;
      brk       <= 1'b0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      sync_q    <= {sync_q[0], uart_rx};
      cnt       <= cnt_nxt;
      shreg     <= shreg_nxt;
      bit_idx   <= bit_idx_nxt;
      brk       <= brk_nxt;
      rx_byte   <= rx_byte_nxt;
      rx_valid  <= rx_valid_nxt;
      frame_err <= frame_err_nxt;
`ifdef UART_RX_PARITY_EN
      par_bad   <= par_bad_nxt;
`endif
    end
  end

endmodule

// File: rtl/uart_reg_cmd_rx.sv
// Parses "r<0-7>=<4 hex><CR|LF>" from the UART byte stream into register write strobes.
// UART_RX_PARITY_EN selects 8E1 framing in the PHY.
module uart_reg_cmd_rx
  import uart_cmd_pkg::*;
#(
  parameter int CLK_HZ = 27_000_000,
  parameter int BAUD   = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        wr_en,
  output logic [2:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        cmd_err
);

  localparam int DIV = CLK_HZ / BAUD;

  uart_rx_phy #(.DIV(DIV)) u_phy (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  parse_state_t pstate, pstate_nxt;
  logic [1:0]   nib_cnt, nib_cnt_nxt;
  logic [15:0]  acc, acc_nxt;
  logic [2:0]   addr_acc, addr_acc_nxt;
  logic         wr_en_nxt;
  logic [2:0]   wr_addr_nxt;
  logic [15:0]  wr_data_nxt;
  logic         cmd_err_q, cmd_err_nxt;
  logic [4:0]   nib;
  logic         is_term;
  logic         bad;
  logic         fe_hit;

  // A frame error only matters while a command is partially assembled.
  assign fe_hit  = frame_err && (pstate != P_R) && (pstate != P_SYNC);
  assign cmd_err = cmd_err_q | fe_hit;

  always_comb begin
    pstate_nxt   = pstate;
    nib_cnt_nxt  = nib_cnt;
    acc_nxt      = acc;
    addr_acc_nxt = addr_acc;
    wr_en_nxt    = 1'b0;
    wr_addr_nxt  = wr_addr;
    wr_data_nxt  = wr_data;
    cmd_err_nxt  = 1'b0;
    bad          = 1'b0;
    nib          = hex2nib(rx_byte);
    is_term      = (rx_byte == CH_CR) || (rx_byte == CH_LF);
    if (rx_valid) begin
      case (pstate)
        P_R: begin
          if (rx_byte == CH_R) pstate_nxt = P_IDX;
          else if (!is_term)   bad = 1'b1;
        end
        P_IDX: begin
          if (rx_byte >= CH_0 && rx_byte <= CH_7) begin
            addr_acc_nxt = rx_byte[2:0];
            pstate_nxt   = P_EQ;
          end else begin
            bad = 1'b1;
          end
        end
        P_EQ: begin
          if (rx_byte == CH_EQ) begin
            nib_cnt_nxt = 2'd0;
            pstate_nxt  = P_HEX;
          end else begin
            bad = 1'b1;
          end
        end
        P_HEX: begin
          if (nib[4]) begin
            acc_nxt     = {acc[11:0], nib[3:0]};
            nib_cnt_nxt = nib_cnt + 2'd1;
            if (nib_cnt == 2'd3) pstate_nxt = P_EOL;
          end else begin
            bad = 1'b1;
          end
        end
        P_EOL: begin
          if (is_term) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = addr_acc;
            wr_data_nxt = acc;
            pstate_nxt  = P_R;
          end else begin
            bad = 1'b1;
          end
        end
        P_SYNC: begin
          if (is_term) pstate_nxt = P_R;
        end
        default: pstate_nxt = P_R;
      endcase
      if (bad) begin
        cmd_err_nxt = 1'b1;
        pstate_nxt  = is_term ? P_R : P_SYNC;
      end
    end else if (fe_hit) begin
      pstate_nxt = P_SYNC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pstate    <= P_R;
      nib_cnt   <= '0;
      acc       <= '0;
      addr_acc  <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      pstate    <= pstate_nxt;
      nib_cnt   <= nib_cnt_nxt;
      acc       <= acc_nxt;
      addr_acc  <= addr_acc_nxt;
      wr_en     <= wr_en_nxt;
      wr_addr   <= wr_addr_nxt;
      wr_data   <= wr_data_nxt;
      cmd_err_q <= cmd_err_nxt;
    end
  end

endmodule
